// File: rtl/fx_denorm16_pipe.sv
// fx_denorm16_pipe: four-stage (8/4/2/1) right-shift denormalizer with guard/sticky tracking and optional round-half-up
module fx_denorm16_pipe #(
    parameter int WIDTH = 16,
    parameter int ROUND = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_mant,
    input  logic [3:0]       io_in_shamt,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_data,
    output logic             io_out_sticky,
    output logic             io_out_zero
);
    // returns {shifted data, guard, sticky}
    function automatic logic [WIDTH+1:0] stg(input logic [WIDTH-1:0] x, input logic b, input logic gi,
                                              input logic si, input logic [3:0] n);
        logic [WIDTH-1:0] m;
        m = (WIDTH'(1) << (n - 4'd1)) - WIDTH'(1);
        return b ? {x >> n, x[n - 4'd1], si | gi | (|(x & m))} : {x, gi, si};
    endfunction
    logic             v0, v1, v2, v3, a0, a1, a2, a3;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic             g0, g1, g2, s0, s1, s2, s3;
    logic [2:0]       sh0;
    logic [1:0]       sh1;
    logic             sh2;
    logic [WIDTH+1:0] t0, t1, t2, t3;
    always_comb begin
        a3 = !v3 || io_out_ready;
        a2 = !v2 || a3;
        a1 = !v1 || a2;
        a0 = !v0 || a1;
        t0 = stg(io_in_mant, io_in_shamt[3], 1'b0, 1'b0, 4'd8);
        t1 = stg(d0, sh0[2], g0, s0, 4'd4);
        t2 = stg(d1, sh1[1], g1, s1, 4'd2);
        t3 = stg(d2, sh2, g2, s2, 4'd1);
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            {v0, v1, v2, v3} <= '0;
            {d0, d1, d2, d3} <= '0;
            {g0, g1, g2, s0, s1, s2, s3} <= '0;
            {sh0, sh1, sh2} <= '0;
        end else begin
            if (a0) begin
                v0 <= io_in_valid;
                {d0, g0, s0} <= t0;
                sh0 <= io_in_shamt[2:0];
            end
            if (a1) begin
                v1 <= v0;
                {d1, g1, s1} <= t1;
                sh1 <= sh0[1:0];
            end
            if (a2) begin
                v2 <= v1;
                {d2, g2, s2} <= t2;
                sh2 <= sh1[0];
            end
            if (a3) begin
                v3 <= v2;
                d3 <= t3[WIDTH+1:2] + WIDTH'(ROUND != 0 && t3[1]);
                s3 <= t3[1] | t3[0];
            end
        end
    end
    assign io_in_ready   = a0;
    assign io_out_valid  = v3;
    assign io_out_data   = d3;
    assign io_out_sticky = s3;
    assign io_out_zero   = d3 == '0;
endmodule
